// File: rtl/gpi_conditioner.sv
// Input conditioning for the GPI capture register: per-bit two-flop synchroniser,
// stability-count debounce, and sticky rise/fall status with write-1-to-clear and irq.
module gpi_conditioner #(
    parameter int WIDTH      = 8,
    parameter int DEB_CYCLES = 16,
    parameter int CNT_W      = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pins_in,
    input  logic [WIDTH-1:0] clr_edge,
    output logic [WIDTH-1:0] deb_out,
    output logic [WIDTH-1:0] rise_sts,
    output logic [WIDTH-1:0] fall_sts,
    output logic             irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;
    logic [WIDTH-1:0] deb_q,  deb_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch appears.
    always_comb begin
        deb_d  = deb_q;
        rise_d = rise_q & ~clr_edge;
        fall_d = fall_q & ~clr_edge;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    // Setting after the clear term makes a same-edge set win over clr_edge.
                    deb_d[i] = sync2_q[i];
                    if (sync2_q[i]) begin
                        rise_d[i] = 1'b1;
                    end else begin
                        fall_d[i] = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            // NOTE: the counter array is reset too, so a debounce interrupted by reset restarts from zero.
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= pins_in;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign deb_out  = deb_q;
    assign rise_sts = rise_q;
    assign fall_sts = fall_q;
    assign irq      = |(rise_q | fall_q);

endmodule

// File: tb/tb_gpi_conditioner.sv
// Scoreboard bench for gpi_conditioner: stimulus queues edge-stamped expected outputs,
// a monitor compares them at the matching clock edge.
module tb_gpi_conditioner;

    logic       clk;
    logic       rst_n;
    logic [7:0] pins_in;
    logic [7:0] clr_edge;
    logic [7:0] deb_out;
    logic [7:0] rise_sts;
    logic [7:0] fall_sts;
    logic       irq;

    gpi_conditioner #(
        .WIDTH      (8),
        .DEB_CYCLES (16),
        .CNT_W      (5)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pins_in  (pins_in),
        .clr_edge (clr_edge),
        .deb_out  (deb_out),
        .rise_sts (rise_sts),
        .fall_sts (fall_sts),
        .irq      (irq)
    );

    typedef struct {
        int         at;
        logic [7:0] deb;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       irq;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   base   = 0;
    int   n_vec  = 0;
    int   n_err  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: counts edges and compares every entry due on this edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            edge_n++;
            while (sb.size() > 0 && sb[0].at <= edge_n) begin
                e = sb.pop_front();
                n_vec++;
                if (e.at != edge_n || deb_out !== e.deb || rise_sts !== e.rise ||
                    fall_sts !== e.fall || irq !== e.irq) begin
                    n_err++;
                    $display("FAIL %s @edge %0d (due %0d): got deb=%h rise=%h fall=%h irq=%b, want deb=%h rise=%h fall=%h irq=%b",
                             e.name, edge_n, e.at, deb_out, rise_sts, fall_sts, irq,
                             e.deb, e.rise, e.fall, e.irq);
                end
            end
        end
    end

    task automatic check(input logic ok, input string name);
        n_vec++;
        if (ok !== 1'b1) begin
            n_err++;
            $display("FAIL %s @edge %0d: deb=%h rise=%h fall=%h irq=%b",
                     name, edge_n, deb_out, rise_sts, fall_sts, irq);
        end
    endtask

    task automatic expect_at(input int at, input logic [7:0] deb, input logic [7:0] rise,
                             input logic [7:0] fall, input string name);
        exp_t e;
        e.at   = at;
        e.deb  = deb;
        e.rise = rise;
        e.fall = fall;
        e.irq  = |(rise | fall);
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_pins(input logic [7:0] p);
        pins_in = p;
        base    = edge_n;
    endtask

    // Pulse clr_edge for one cycle; all flags are expected clear afterwards.
    task automatic clear(input logic [7:0] mask, input logic [7:0] deb, input string name);
        clr_edge = mask;
        expect_at(edge_n + 1, deb, 8'h00, 8'h00, name);
        step(1);
        clr_edge = 8'h00;
    endtask

    initial begin
        rst_n    = 1'b0;
        pins_in  = 8'hFF;
        clr_edge = 8'h00;

        // Reset with pins high, then release: full latency and rise on every bit.
        @(negedge clk);
        expect_at(edge_n + 1, 8'h00, 8'h00, 8'h00, "reset_state");
        step(1);
        rst_n = 1'b1;
        base  = edge_n;
        expect_at(base + 1,  8'h00, 8'h00, 8'h00, "post_release");
        expect_at(base + 17, 8'h00, 8'h00, 8'h00, "release_edge17");
        expect_at(base + 18, 8'hFF, 8'hFF, 8'h00, "release_edge18_rise");
        step(18);
        check(deb_out === 8'hFF, "direct_release_deb");
        check(rise_sts === 8'hFF, "direct_release_rise");
        check(irq === 1'b1, "direct_release_irq");
        clear(8'hFF, 8'hFF, "clear_all_rise");
        check(irq === 1'b0, "direct_clear_irq_low");

        // All pins low: falls on every bit.
        set_pins(8'h00);
        expect_at(base + 17, 8'hFF, 8'h00, 8'h00, "all_low_edge17");
        expect_at(base + 18, 8'h00, 8'h00, 8'hFF, "all_low_edge18_fall");
        step(18);
        clear(8'hFF, 8'h00, "clear_all_fall");

        // Bit 3 short pulse is rejected; a later full hold takes exactly 18 edges.
        set_pins(8'h08);
        expect_at(base + 18, 8'h00, 8'h00, 8'h00, "pulse3_no_deb");
        expect_at(base + 24, 8'h00, 8'h00, 8'h00, "pulse3_still_no_deb");
        step(10);
        pins_in = 8'h00;
        step(14);
        set_pins(8'h08);
        expect_at(base + 17, 8'h00, 8'h00, 8'h00, "bit3_hold_edge17");
        expect_at(base + 18, 8'h08, 8'h08, 8'h00, "bit3_hold_edge18");
        step(18);
        clear(8'h08, 8'h08, "clear_rise3");
        set_pins(8'h00);
        expect_at(base + 18, 8'h00, 8'h00, 8'h08, "bit3_fall");
        step(18);
        clear(8'h08, 8'h00, "clear_fall3");

        // Bit 0: high 12, low 1, high; the glitch restarts the count.
        set_pins(8'h01);
        expect_at(base + 18, 8'h00, 8'h00, 8'h00, "glitch0_no_early_rise");
        expect_at(base + 30, 8'h00, 8'h00, 8'h00, "glitch0_edge30");
        expect_at(base + 31, 8'h01, 8'h01, 8'h00, "glitch0_edge31_rise");
        step(12);
        pins_in = 8'h00;
        step(1);
        pins_in = 8'h01;
        step(18);
        clear(8'h01, 8'h01, "clear_rise0");

        // Bit 0 drops: fall at edge 18, clr_edge drops fall_sts and irq next cycle.
        set_pins(8'h00);
        expect_at(base + 17, 8'h01, 8'h00, 8'h00, "drop0_edge17");
        expect_at(base + 18, 8'h00, 8'h00, 8'h01, "drop0_edge18_fall");
        step(18);
        clear(8'h01, 8'h00, "clear_fall0_irq_low");

        // Bit 5: clr_edge on the same edge the rise is set; set wins.
        set_pins(8'h20);
        expect_at(base + 18, 8'h20, 8'h20, 8'h00, "set_beats_clr5");
        expect_at(base + 19, 8'h20, 8'h20, 8'h00, "rise5_held");
        step(17);
        clr_edge = 8'h20;
        step(1);
        clr_edge = 8'h00;
        step(1);
        clear(8'h20, 8'h20, "clear_rise5");

        // Bit 7: reset at count 10 of a debounce, then full latency after release.
        set_pins(8'hA0);
        step(12);
        rst_n = 1'b0;
        expect_at(edge_n + 1, 8'h00, 8'h00, 8'h00, "reset_mid_debounce");
        expect_at(edge_n + 2, 8'h00, 8'h00, 8'h00, "reset_held");
        step(2);
        rst_n = 1'b1;
        base  = edge_n;
        expect_at(base + 17, 8'h00, 8'h00, 8'h00, "rerelease_edge17");
        expect_at(base + 18, 8'hA0, 8'hA0, 8'h00, "rerelease_edge18_rise");
        step(18);
        step(2);
        check(deb_out === 8'hA0, "direct_rerelease_deb");
        check(rise_sts === 8'hA0, "direct_rerelease_rise");
        check(fall_sts === 8'h00, "direct_rerelease_fall");
        check(irq === 1'b1, "direct_rerelease_irq");

        // Anything still queued was never compared.
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_vec++;
            n_err++;
            $display("FAIL %s: never reached, due edge %0d, now edge %0d", e.name, e.at, edge_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
